// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci display sequencer.
package fib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } fib_state_e;

  localparam int IDX_W = 6;
  localparam int A0    = 0;
  localparam int B0    = 1;

endpackage

// File: rtl/fib_datapath.sv
// Two-register Fibonacci datapath (a <= b, b <= a+b) with carry-out flag and index counter.
module fib_datapath
  import fib_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             reinit,
  output logic [WIDTH-1:0] a,
  output logic             b_ovf,
  output logic [IDX_W-1:0] index
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             b_ovf_q, b_ovf_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    a_d     = a_q;
    b_d     = b_q;
    b_ovf_d = b_ovf_q;
    index_d = index_q;
    if (reinit) begin
      a_d     = WIDTH'(A0);
      b_d     = WIDTH'(B0);
      b_ovf_d = 1'b0;
      index_d = '0;
    end else if (advance) begin
      // b_ovf marks that b no longer fits, so a is the last representable term
      a_d     = b_q;
      b_d     = sum[WIDTH-1:0];
      b_ovf_d = sum[WIDTH];
      index_d = index_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= WIDTH'(A0);
      b_q     <= WIDTH'(B0);
      b_ovf_q <= 1'b0;
      index_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      b_ovf_q <= b_ovf_d;
      index_q <= index_d;
    end
  end

  assign a     = a_q;
  assign b_ovf = b_ovf_q;
  assign index = index_q;

endmodule

// File: rtl/fib_sequencer.sv
// Fibonacci display controller: tick prescaler, run/pause/step/done FSM, end-of-sequence handling.
// Optional BCD converter output enabled by defining FIB_SEQUENCER_BCD_EN.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             step,
  input  logic             clear,
  input  logic             mode_wrap,
  output logic [WIDTH-1:0] fib_value,
  output logic [5:0]       fib_index,
  output logic             adv_strobe,
  output logic             busy,
  output logic             done,
`ifdef FIB_SEQUENCER_BCD_EN
  output logic [4*((WIDTH <= 9) ? 3 : 10)-1:0] bcd_out,
  output logic             bcd_valid,
`endif
  output logic             ovf
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  fib_state_e       state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             adv_strobe_q, adv_strobe_d;
  logic             ovf_q, ovf_d;
  logic             tick, adv_req, dp_advance, dp_reinit, dp_b_ovf;
  logic [WIDTH-1:0] dp_a;
  logic [IDX_W-1:0] dp_index;

  fib_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk     (clk),
    .reset   (reset),
    .advance (dp_advance),
    .reinit  (dp_reinit),
    .a       (dp_a),
    .b_ovf   (dp_b_ovf),
    .index   (dp_index)
  );

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    adv_req      = 1'b0;
    dp_advance   = 1'b0;
    dp_reinit    = 1'b0;
    adv_strobe_d = 1'b0;
    ovf_d        = 1'b0;
    tick         = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

    if (clear) begin
      state_d   = ST_IDLE;
      presc_d   = '0;
      dp_reinit = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        ST_RUN: begin
          adv_req = tick;
          if (tick)
            presc_d = '0;
          else if (!(pause && !start))
            presc_d = presc_q + PW'(1);
          if (pause && !start)
            state_d = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (start)
            state_d = ST_RUN;
          else if (step)
            adv_req = 1'b1;
        end
        default: begin
          if (start) begin
            state_d   = ST_RUN;
            presc_d   = '0;
            dp_reinit = 1'b1;
          end
        end
      endcase

      // End of sequence: either restart from F0 in place or freeze in DONE
      if (adv_req) begin
        if (dp_b_ovf) begin
          ovf_d = 1'b1;
          if (mode_wrap) begin
            dp_reinit    = 1'b1;
            adv_strobe_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          dp_advance   = 1'b1;
          adv_strobe_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      adv_strobe_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      adv_strobe_q <= adv_strobe_d;
      ovf_q        <= ovf_d;
    end
  end

  assign fib_value  = dp_a;
  assign fib_index  = dp_index;
  assign adv_strobe = adv_strobe_q;
  assign ovf        = ovf_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);

`ifdef FIB_SEQUENCER_BCD_EN
  localparam int BCD_DIGITS = (WIDTH <= 9) ? 3 : 10;
  localparam int BW         = 4 * BCD_DIGITS;

  logic [WIDTH-1:0] bcd_bin_q, bcd_bin_d, src_bin;
  logic [BW-1:0]    bcd_shift_q, bcd_shift_d, src_bcd, adj, step_bcd;
  logic [BW-1:0]    bcd_out_q, bcd_out_d;
  logic [5:0]       bcd_cnt_q, bcd_cnt_d;
  logic             bcd_busy_q, bcd_busy_d;
  logic             bcd_valid_q, bcd_valid_d;

  // A load performs the first shift-add-3 step directly on fib_value
  assign src_bcd = adv_strobe_q ? '0 : bcd_shift_q;
  assign src_bin = adv_strobe_q ? dp_a : bcd_bin_q;

  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
    assign adj[4*gi +: 4] = (src_bcd[4*gi +: 4] >= 4'd5) ? src_bcd[4*gi +: 4] + 4'd3
                                                        : src_bcd[4*gi +: 4];
  end

  assign step_bcd = {adj[BW-2:0], src_bin[WIDTH-1]};

  always_comb begin
    bcd_bin_d   = bcd_bin_q;
    bcd_shift_d = bcd_shift_q;
    bcd_out_d   = bcd_out_q;
    bcd_cnt_d   = bcd_cnt_q;
    bcd_busy_d  = bcd_busy_q;
    bcd_valid_d = bcd_valid_q;
    if (adv_strobe_q || bcd_busy_q) begin
      bcd_shift_d = step_bcd;
      bcd_bin_d   = {src_bin[WIDTH-2:0], 1'b0};
      if (adv_strobe_q) begin
        bcd_cnt_d   = 6'd1;
        bcd_busy_d  = 1'b1;
        bcd_valid_d = 1'b0;
      end else begin
        bcd_cnt_d = bcd_cnt_q + 6'd1;
        if (bcd_cnt_q == 6'(WIDTH - 1)) begin
          bcd_busy_d  = 1'b0;
          bcd_out_d   = step_bcd;
          bcd_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_bin_q   <= '0;
      bcd_shift_q <= '0;
      bcd_out_q   <= '0;
      bcd_cnt_q   <= '0;
      bcd_busy_q  <= 1'b0;
      bcd_valid_q <= 1'b0;
    end else begin
      bcd_bin_q   <= bcd_bin_d;
      bcd_shift_q <= bcd_shift_d;
      bcd_out_q   <= bcd_out_d;
      bcd_cnt_q   <= bcd_cnt_d;
      bcd_busy_q  <= bcd_busy_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign bcd_out   = bcd_out_q;
  assign bcd_valid = bcd_valid_q;
`endif

endmodule
